// File: rtl/cla_seq_alu.sv
// Nibble-serial 32-bit add/subtract: one 4-bit carry-lookahead slice is reused
// across the operand, one nibble per clock, with a start/done handshake.

module cla_add (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Every carry is expanded from i_cin, so no carry waits on a lower one.
  assign w_c1   = w_g[0] | (w_p[0] & i_cin);
  assign w_c2   = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c3   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign o_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum = w_p ^ {w_c3, w_c2, w_c1, i_cin};
endmodule

// state | meaning
// IDLE  | waiting for i_start; ready
// RUN   | one nibble per clock through the shared slice
// FIN   | o_done pulse; i_start accepted for a back-to-back operation
module cla_seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_op_sub,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_zero
);
  localparam int N  = WIDTH / 4;
  localparam int IW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_cy;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_sum;
  logic             w_cout;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_next;

  assign w_a_nib  = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib  = r_b[{r_idx, 2'b00} +: 4];
  assign w_last   = (r_idx == IW'(N - 1));
  assign w_accept = i_start && (r_state != S_RUN);

  cla_add u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_cy),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Accumulator as it will look after this edge; the final flags need the new top nibble.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[{r_idx, 2'b00} +: 4] = w_sum;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cy     <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          if (w_accept) begin
            r_a     <= i_opa;
            r_b     <= i_op_sub ? ~i_opb : i_opb;
            r_cy    <= i_op_sub;
            r_idx   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cy  <= w_cout;
          if (w_last) begin
            r_state  <= S_FIN;
            r_result <= w_acc_next;
            r_carry  <= w_cout;
            r_ovf    <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                        (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
            r_zero   <= (w_acc_next == '0);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready  = (r_state == S_IDLE) || (r_state == S_FIN);
  assign o_busy   = (r_state == S_RUN);
  assign o_done   = (r_state == S_FIN);
  assign o_result = r_result;
  assign o_carry  = r_carry;
  assign o_ovf    = r_ovf;
  assign o_zero   = r_zero;
endmodule
